// File: rtl/icesid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icesid_pkg
//  Description : Shared types, widths and helpers for the output mixer path.
//                Provides the mixer state enum, datapath widths and the
//                17-bit saturating helper applied to the scaled product.
//  Revision    : 1.0 - initial release
// ============================================================================
package icesid_pkg;

  localparam int SAMPLE_W     = 16;  // signed channel sample
  localparam int MIX_W        = 17;  // signed pre-saturated mix handed to the clipper
  localparam int ACC_W        = 19;  // frame accumulator, headroom for 8 full-scale channels
  localparam int PROD_W       = 23;  // accumulator times 4-bit volume
  localparam int VOL_W        = 4;   // master volume 0..15
  localparam int STEP_W       = 2;   // indexes the VOL_W shift-add steps
  localparam int CNT_W        = 3;   // channel counter, up to 8 channels
  localparam int MAX_CHANNELS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } mix_state_t;

  localparam logic signed [PROD_W-1:0] MIX_MAX = 23'sd65535;
  localparam logic signed [PROD_W-1:0] MIX_MIN = -23'sd65536;

  // Divide the product by 16 (floor toward minus infinity) and clamp to the
  // signed 17-bit range expected downstream.
  function automatic logic signed [MIX_W-1:0] saturate_mix(
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W-1:0] shifted;
    shifted = prod >>> 4;
    if (shifted > MIX_MAX) begin
      return MIX_W'(MIX_MAX);
    end else if (shifted < MIX_MIN) begin
      return MIX_W'(MIX_MIN);
    end
    return MIX_W'(shifted);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_mixer_if
//  Description : Frame-control, sample stream and result bundle of the
//                sample mixer.
//                  iStart/iEnable/iVolume : frame start, channel mask, volume
//                  iSample/iSampleValid   : channel sample stream (in)
//                  oSampleReady           : mixer accepts a sample this cycle
//                  oMix/oMixValid         : 17-bit signed result + pulse
//                  oBusy                  : frame in progress
//                master = driver of samples, slave = the mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sample_mixer_if
  import icesid_pkg::*;
#(
  parameter int CHANNELS = 4
);

  logic                       iStart;
  logic [CHANNELS-1:0]        iEnable;
  logic [VOL_W-1:0]           iVolume;
  logic signed [SAMPLE_W-1:0] iSample;
  logic                       iSampleValid;
  logic                       oSampleReady;
  logic signed [MIX_W-1:0]    oMix;
  logic                       oMixValid;
  logic                       oBusy;

  modport master (
    output iStart, iEnable, iVolume, iSample, iSampleValid,
    input  oSampleReady, oMix, oMixValid, oBusy
  );

  modport slave (
    input  iStart, iEnable, iVolume, iSample, iSampleValid,
    output oSampleReady, oMix, oMixValid, oBusy
  );

endinterface
`default_nettype wire

// File: rtl/mix_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : mix_scaler
//  Description : Sequential 4-step shift-add multiply of the frame sum by the
//                master volume (LSB first), followed by >>>4 and saturation
//                to 17 bits.
//                  clk, rst   : clock, synchronous active-high reset
//                  i_start    : pulse, clears the product and begins stepping
//                  i_sum      : signed frame sum, held stable while stepping
//                  i_volume   : 4-bit volume, held stable while stepping
//                  o_result   : saturated result, meaningful when o_done
//                  o_done     : high on the final step
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_scaler
  import icesid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic signed [ACC_W-1:0]  i_sum,
  input  logic [VOL_W-1:0]         i_volume,
  output logic signed [MIX_W-1:0]  o_result,
  output logic                     o_done
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(VOL_W - 1);

  logic                     active_q, active_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;

  logic signed [PROD_W-1:0] sum_ext;
  logic signed [PROD_W-1:0] addend;
  logic signed [PROD_W-1:0] prod_sum;

  assign sum_ext  = {{(PROD_W-ACC_W){i_sum[ACC_W-1]}}, i_sum};
  assign addend   = i_volume[step_q] ? (sum_ext <<< step_q) : '0;
  assign prod_sum = prod_q + addend;

  // The result is taken from the product including this cycle's partial
  // term, so the caller can register it on the same edge that ends the
  // final step.
  assign o_result = saturate_mix(prod_sum);

  always_comb begin
    active_d = active_q;
    step_d   = step_q;
    prod_d   = prod_q;
    o_done   = 1'b0;
    if (i_start) begin
      active_d = 1'b1;
      step_d   = '0;
      prod_d   = '0;
    end else if (active_q) begin
      prod_d = prod_sum;
      step_d = step_q + 1'b1;
      if (step_q == LAST_STEP) begin
        o_done   = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      step_q   <= '0;
      prod_q   <= '0;
    end else begin
      active_q <= active_d;
      step_q   <= step_d;
      prod_q   <= prod_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_mixer
//  Description : Time-multiplexed output mixer. Accumulates one frame of
//                CHANNELS signed 16-bit samples with per-channel muting,
//                scales by a 4-bit master volume and emits a 17-bit signed
//                pre-saturated mix for the output clipper.
//                  iClk, iRst : clock, synchronous active-high reset
//                  bus        : sample_mixer_if slave (start/mask/volume,
//                               sample stream, result, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_mixer
  import icesid_pkg::*;
#(
  parameter int CHANNELS = 4   // 2..8
)(
  input  logic          iClk,
  input  logic          iRst,
  sample_mixer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

  mix_state_t               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CHANNELS-1:0]      enable_q, enable_d;
  logic [VOL_W-1:0]         volume_q, volume_d;
  logic signed [MIX_W-1:0]  mix_q, mix_d;
  logic                     mix_valid_q, mix_valid_d;

  logic                     accept;
  logic                     scale_start;
  logic                     scale_done;
  logic signed [MIX_W-1:0]  scale_result;
  logic [MAX_CHANNELS-1:0]  enable_padded;
  logic signed [ACC_W-1:0]  sample_ext;

  assign accept        = (state_q == ST_ACCUM) && bus.iSampleValid;
  // Widen the mask so the 3-bit channel counter can index it directly.
  assign enable_padded = MAX_CHANNELS'(enable_q);
  assign sample_ext    = {{(ACC_W-SAMPLE_W){bus.iSample[SAMPLE_W-1]}}, bus.iSample};

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    enable_d    = enable_q;
    volume_d    = volume_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    scale_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          enable_d = bus.iEnable;
          volume_d = bus.iVolume;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          // A muted channel still consumes its slot in the frame.
          if (enable_padded[cnt_q]) begin
            acc_d = acc_q + sample_ext;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CH) begin
            cnt_d       = '0;
            scale_start = 1'b1;
            state_d     = ST_SCALE;
          end
        end
      end

      ST_SCALE: begin
        // Load the result on the last multiply step so it is visible in
        // the DONE cycle together with the valid pulse.
        if (scale_done) begin
          mix_d       = scale_result;
          mix_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      enable_q    <= '0;
      volume_q    <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      enable_q    <= enable_d;
      volume_q    <= volume_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  // acc_q and volume_q are stable for the whole SCALE phase.
  mix_scaler u_mix_scaler (
    .clk      (iClk),
    .rst      (iRst),
    .i_start  (scale_start),
    .i_sum    (acc_q),
    .i_volume (volume_q),
    .o_result (scale_result),
    .o_done   (scale_done)
  );

  assign bus.oSampleReady = (state_q == ST_ACCUM);
  assign bus.oBusy        = (state_q != ST_IDLE);
  assign bus.oMix         = mix_q;
  assign bus.oMixValid    = mix_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_mixer
//  Description : Self-checking bench for sample_mixer. A frame-level model
//                (sum of enabled samples, times volume, floor-divide by 16,
//                clamp) predicts each mix; a compare process checks every
//                cycle that oMix only changes on oMixValid and carries the
//                predicted value. Directed frames also pin literal results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_mixer;

  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sample_mixer_if #(.CHANNELS(CH)) bus ();

  sample_mixer #(.CHANNELS(CH)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int     checks = 0;
  int     errors = 0;
  longint exp_q[$];
  longint last_mix = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: plain integer arithmetic on the whole frame.
  function automatic longint model(input logic [CH-1:0] mask, input int vol,
                                   input int s[CH]);
    longint sum, p, q;
    sum = 0;
    for (int c = 0; c < CH; c++) if (mask[c]) sum += s[c];
    p = sum * vol;
    if (p >= 0) q = p / 16;
    else        q = -((-p + 15) / 16);
    if (q > 65535)  q = 65535;
    if (q < -65536) q = -65536;
    return q;
  endfunction

  // Compare process: every cycle outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_mix = 0;
      end else if (bus.oMixValid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mix_valid", 1, 0);
        end else begin
          longint e;
          e = exp_q.pop_front();
          chk("mix_value", $signed(bus.oMix), e);
          last_mix = e;
        end
      end else begin
        chk("mix_hold", $signed(bus.oMix), last_mix);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input bit noise);
    bus.iEnable = CH'($urandom);
    bus.iVolume = 4'($urandom);
    if (noise) bus.iStart = 1'($urandom);
  endtask

  task automatic do_reset();
    bus.iStart       = 1'b0;
    bus.iSampleValid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mix",   $signed(bus.oMix), 0);
    chk("rst_valid", bus.oMixValid, 0);
    chk("rst_busy",  bus.oBusy, 0);
    chk("rst_ready", bus.oSampleReady, 0);
    repeat (8) begin
      chk("rst_no_valid", bus.oMixValid, 0);
      tick();
    end
  endtask

  // abort: 0 none, 1 reset mid-ACCUM, 2 reset mid-SCALE
  task automatic do_frame(input logic [CH-1:0] mask, input int vol, input int s[CH],
                          input int max_gap, input bit noise, input int abort,
                          input bit has_lit, input longint lit);
    int     n;
    bit     got;
    longint mix;
    got = 1'b0;
    mix = 0;
    bus.iStart = 1'b0;
    if (noise) begin
      repeat (2) begin
        bus.iSampleValid = 1'b1;
        bus.iSample      = 16'($urandom);
        chk("ready_idle", bus.oSampleReady, 0);
        tick();
      end
    end
    bus.iSampleValid = 1'b0;
    bus.iStart  = 1'b1;
    bus.iEnable = mask;
    bus.iVolume = 4'(vol);
    tick();
    bus.iStart = 1'b0;
    chk("busy_after_start",  bus.oBusy, 1);
    chk("ready_after_start", bus.oSampleReady, 1);
    for (int c = 0; c < CH; c++) begin
      int gap;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
        bus.iSampleValid = 1'b0;
        bus.iSample      = 16'($urandom);
        scramble(noise);
        tick();
      end
      if (abort == 1 && c == 2) begin
        do_reset();
        return;
      end
      bus.iSampleValid = 1'b1;
      bus.iSample      = 16'(s[c]);
      scramble(noise);
      chk("ready_accum", bus.oSampleReady, 1);
      tick();
    end
    bus.iSampleValid = 1'b0;
    if (abort == 0) exp_q.push_back(model(mask, vol, s));
    n = 1;
    while (n <= 12) begin
      if (abort == 2 && n == 3) begin
        do_reset();
        return;
      end
      if (bus.oMixValid) begin
        got = 1'b1;
        mix = $signed(bus.oMix);
        break;
      end
      chk("busy_scale",  bus.oBusy, 1);
      chk("ready_scale", bus.oSampleReady, 0);
      scramble(noise);
      tick();
      n++;
    end
    chk("valid_latency", n, 5);
    if (got && has_lit) chk("mix_literal", mix, lit);
    chk("busy_done", bus.oBusy, 1);
    bus.iStart = noise;          // start in the DONE cycle must be ignored
    tick();
    bus.iStart = 1'b0;
    chk("valid_single_cycle", bus.oMixValid, 0);
    chk("busy_low_after",     bus.oBusy, 0);
  endtask

  initial begin
    int s[CH];
    bus.iStart       = 1'b0;
    bus.iEnable      = '0;
    bus.iVolume      = '0;
    bus.iSample      = '0;
    bus.iSampleValid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_mix",   $signed(bus.oMix), 0);
    chk("reset_valid", bus.oMixValid, 0);
    chk("reset_busy",  bus.oBusy, 0);
    chk("reset_ready", bus.oSampleReady, 0);

    s = '{1000, 2000, 3000, 4000};
    do_frame(4'b1111, 15, s, 0, 1'b0, 0, 1'b1, 9375);
    s = '{32767, 32767, 32767, 32767};
    do_frame(4'b1111, 15, s, 0, 1'b0, 0, 1'b1, 65535);
    s = '{-32768, -32768, -32768, -32768};
    do_frame(4'b1111, 15, s, 0, 1'b0, 0, 1'b1, -65536);
    s = '{100, 200, 300, 400};
    do_frame(4'b0101, 8, s, 0, 1'b0, 0, 1'b1, 200);
    do_frame(4'b0101, 0, s, 0, 1'b0, 0, 1'b1, 0);
    s = '{-1, 0, 0, 0};
    do_frame(4'b0001, 1, s, 0, 1'b0, 0, 1'b1, -1);
    s = '{15, 0, 0, 0};
    do_frame(4'b0001, 1, s, 0, 1'b0, 0, 1'b1, 0);

    s = '{1000, 2000, 3000, 4000};
    do_frame(4'b1111, 15, s, 3, 1'b1, 0, 1'b1, 9375);
    do_frame(4'b1111, 15, s, 1, 1'b0, 1, 1'b0, 0);
    do_frame(4'b1111, 15, s, 0, 1'b0, 0, 1'b1, 9375);
    do_frame(4'b1111, 15, s, 2, 1'b1, 2, 1'b0, 0);
    do_frame(4'b1111, 15, s, 0, 1'b0, 0, 1'b1, 9375);

    for (int f = 0; f < 40; f++) begin
      logic [CH-1:0] m;
      int            v;
      m = CH'($urandom);
      v = $urandom_range(15, 0);
      for (int c = 0; c < CH; c++) begin
        logic [15:0] raw;
        raw = 16'($urandom);
        if ($urandom_range(3, 0) == 0) raw = raw[0] ? 16'h7fff : 16'h8000;
        s[c] = int'($signed(raw));
      end
      do_frame(m, v, s, 3, 1'($urandom), 0, 1'b0, 0);
    end

    repeat (3) tick();
    chk("no_pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
